// File: rtl/traffic_phase_scheduler.sv
// Round-robin, demand-actuated phase scheduler for a four-way intersection.
// Define TRAFFIC_EMERGENCY_EN to compile in the emergency-preemption path.
module traffic_phase_scheduler #(
    parameter int unsigned GREEN_MIN   = 4,
    parameter int unsigned GREEN_MAX   = 10,
    parameter int unsigned YELLOW_TIME = 2,
    parameter int unsigned ALLRED_TIME = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_NORTH,
    input  logic       sensor_EAST,
    input  logic       sensor_SOUTH,
    input  logic       sensor_WEST,
    input  logic       emergency_req,
    input  logic [1:0] emergency_dir,
    output logic [2:0] light_NORTH,
    output logic [2:0] light_EAST,
    output logic [2:0] light_WEST,
    output logic [2:0] light_SOUTH,
    output logic [1:0] active_dir,
    output logic [1:0] phase
);

    localparam int unsigned TW = $clog2(GREEN_MAX + 1);
    localparam logic [2:0] LT_RED    = 3'b100;
    localparam logic [2:0] LT_YELLOW = 3'b010;
    localparam logic [2:0] LT_GREEN  = 3'b001;

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    dir_q, dir_d;
    logic [2:0]    light_q [4];
    logic [2:0]    light_d [4];

    logic [3:0]  sens;
    logic        own;
    logic        others;
    logic [31:0] green_n;
    logic        em_valid;
    logic [1:0]  em_dir;
    logic        pick_found;
    logic [1:0]  pick_dir;
    logic [1:0]  cand;
    logic        green_exit;

    // Preemption collapses to constants when not compiled in.
`ifdef TRAFFIC_EMERGENCY_EN
    assign em_valid = emergency_req;
    assign em_dir   = emergency_dir;
`else
    logic unused_emergency;
    assign unused_emergency = ^{emergency_req, emergency_dir};
    assign em_valid = 1'b0;
    assign em_dir   = 2'd0;
`endif

    assign sens    = {sensor_WEST, sensor_SOUTH, sensor_EAST, sensor_NORTH};
    assign own     = sens[dir_q];
    assign others  = |(sens & ~(4'b0001 << dir_q));
    assign green_n = 32'(timer_q) + 32'd1;

    // State, timer, grant and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ALLRED;
            timer_q <= '0;
            dir_q   <= 2'd3;
            for (int d = 0; d < 4; d++) begin
                light_q[d] <= LT_RED;
            end
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dir_q   <= dir_d;
            for (int d = 0; d < 4; d++) begin
                light_q[d] <= light_d[d];
            end
        end
    end

    // Next-state: grant search, green exit rule and phase timing.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        timer_d    = (timer_q == TW'(GREEN_MAX)) ? timer_q : timer_q + TW'(1);
        pick_found = 1'b0;
        pick_dir   = dir_q;
        cand       = dir_q;
        green_exit = 1'b0;

        for (int i = 1; i <= 4; i++) begin
            cand = dir_q + 2'(i);
            if (!pick_found && sens[cand]) begin
                pick_found = 1'b1;
                pick_dir   = cand;
            end
        end
        if (em_valid) begin
            pick_found = 1'b1;
            pick_dir   = em_dir;
        end

        green_exit = others && ((green_n >= GREEN_MIN && !own) || green_n >= GREEN_MAX);
        if (em_valid) begin
            green_exit = (em_dir != dir_q);
        end

        case (state_q)
            ST_ALLRED: begin
                if (timer_q >= TW'(ALLRED_TIME - 1)) begin
                    if (pick_found) begin
                        state_d = ST_GREEN;
                        dir_d   = pick_dir;
                        timer_d = '0;
                    end else begin
                        timer_d = TW'(ALLRED_TIME - 1);
                    end
                end
            end
            ST_GREEN: begin
                if (green_exit) begin
                    state_d = ST_YELLOW;
                    timer_d = '0;
                end
            end
            ST_YELLOW: begin
                if (timer_q >= TW'(YELLOW_TIME - 1)) begin
                    state_d = ST_ALLRED;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = ST_ALLRED;
                timer_d = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so lights register alongside it.
    always_comb begin
        for (int d = 0; d < 4; d++) begin
            light_d[d] = LT_RED;
            if (dir_d == 2'(d)) begin
                if (state_d == ST_GREEN) begin
                    light_d[d] = LT_GREEN;
                end else if (state_d == ST_YELLOW) begin
                    light_d[d] = LT_YELLOW;
                end
            end
        end
    end

    assign light_NORTH = light_q[0];
    assign light_EAST  = light_q[1];
    assign light_SOUTH = light_q[2];
    assign light_WEST  = light_q[3];
    assign active_dir  = dir_q;
    assign phase       = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: per-cycle check against a phase/age model
// plus directed scenarios with hand-computed green/yellow/all-red lengths.
module tb_traffic_phase_scheduler;

    localparam int GMIN = 4;
    localparam int GMAX = 10;
    localparam int YT   = 2;
    localparam int AT   = 1;
`ifdef TRAFFIC_EMERGENCY_EN
    localparam bit EM = 1'b1;
`else
    localparam bit EM = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       sN, sE, sS, sW;
    logic       em_req;
    logic [1:0] em_dir;
    logic [2:0] lN, lE, lS, lW;
    logic [1:0] act;
    logic [1:0] ph;

    int n_vec = 0;
    int n_err = 0;

    traffic_phase_scheduler #(
        .GREEN_MIN  (GMIN),
        .GREEN_MAX  (GMAX),
        .YELLOW_TIME(YT),
        .ALLRED_TIME(AT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sensor_NORTH (sN),
        .sensor_EAST  (sE),
        .sensor_SOUTH (sS),
        .sensor_WEST  (sW),
        .emergency_req(em_req),
        .emergency_dir(em_dir),
        .light_NORTH  (lN),
        .light_EAST   (lE),
        .light_WEST   (lW),
        .light_SOUTH  (lS),
        .active_dir   (act),
        .phase        (ph)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: phase (0 allred, 1 green, 2 yellow), served approach, cycles spent in phase.
    int m_ph  = 0;
    int m_dir = 3;
    int m_age = 0;
    bit m_valid = 1'b0;

    function automatic int next_request(input int from, input bit [3:0] s);
        for (int i = 1; i <= 4; i++) begin
            if (s[(from + i) % 4]) return (from + i) % 4;
        end
        return -1;
    endfunction

    function automatic int exp_light(input int d);
        if (d == m_dir && m_ph == 1) return 1;
        if (d == m_dir && m_ph == 2) return 2;
        return 4;
    endfunction

    always @(posedge clk) begin
        bit [3:0] s;
        int       pick;
        int       n;
        bit       oth;
        bit       ex;
        s = {sW, sS, sE, sN};
        if (reset) begin
            m_ph = 0; m_dir = 3; m_age = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            case (m_ph)
                0: begin
                    if (m_age >= AT - 1) begin
                        pick = next_request(m_dir, s);
                        if (EM && em_req) pick = int'(em_dir);
                        if (pick >= 0) begin
                            m_ph = 1; m_dir = pick; m_age = 0;
                        end
                    end else begin
                        m_age++;
                    end
                end
                1: begin
                    n = m_age + 1;
                    oth = 1'b0;
                    for (int d = 0; d < 4; d++) begin
                        if (d != m_dir && s[d]) oth = 1'b1;
                    end
                    ex = oth && ((n >= GMIN && !s[m_dir]) || n >= GMAX);
                    if (EM && em_req) ex = (int'(em_dir) != m_dir);
                    if (ex) begin
                        m_ph = 2; m_age = 0;
                    end else begin
                        m_age++;
                    end
                end
                default: begin
                    if (m_age + 1 >= YT) begin
                        m_ph = 0; m_age = 0;
                    end else begin
                        m_age++;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_phase",   32'(ph),  32'(m_ph));
            check("cyc_active",  32'(act), 32'(m_dir));
            check("cyc_light_N", 32'(lN),  32'(exp_light(0)));
            check("cyc_light_E", 32'(lE),  32'(exp_light(1)));
            check("cyc_light_S", 32'(lS),  32'(exp_light(2)));
            check("cyc_light_W", 32'(lW),  32'(exp_light(3)));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [2:0] sig(input int sel);
        case (sel)
            0:       return lN;
            1:       return lE;
            2:       return lS;
            3:       return lW;
            default: return {1'b0, ph};
        endcase
    endfunction

    task automatic set_sens(input logic n, input logic e, input logic s, input logic w);
        sN = n; sE = e; sS = s; sW = w;
    endtask

    task automatic do_reset(input int cyc);
        reset = 1'b1;
        step(cyc);
        reset = 1'b0;
    endtask

    task automatic wait_for(input string name, input int sel, input logic [2:0] val, input int bound);
        int k;
        k = 0;
        while (sig(sel) !== val && k < bound) begin
            step(1);
            k++;
        end
        check(name, 32'(sig(sel)), 32'(val));
    endtask

    // Counts consecutive samples (one per cycle) where the selected output holds val.
    task automatic run_len(input string name, input int sel, input logic [2:0] val, input int exp);
        int cnt;
        cnt = 0;
        while (sig(sel) === val && cnt < 100) begin
            cnt++;
            step(1);
        end
        check(name, 32'(cnt), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int d;
        reset = 1'b1;
        set_sens(1'b1, 1'b0, 1'b0, 1'b0);
        em_req = 1'b0;
        em_dir = 2'd0;

        // Reset with only north requesting, then resting north green.
        step(3);
        check("rst_light_N", 32'(lN), 32'd4);
        check("rst_light_E", 32'(lE), 32'd4);
        check("rst_light_S", 32'(lS), 32'd4);
        check("rst_light_W", 32'(lW), 32'd4);
        check("rst_phase",   32'(ph), 32'd0);
        check("rst_active",  32'(act), 32'd3);
        reset = 1'b0;
        check("t1_first_allred", 32'(lN), 32'd4);
        step(1);
        check("t1_n_green",  32'(lN), 32'd1);
        check("t1_phase",    32'(ph), 32'd1);
        check("t1_active",   32'(act), 32'd0);
        step(30);
        check("t1_n_rest",   32'(lN), 32'd1);

        // North and east contend: max-length greens alternate.
        set_sens(1'b1, 1'b1, 1'b0, 1'b0);
        do_reset(2);
        wait_for("t2_n_on", 0, 3'b001, 5);
        run_len("t2_n_green",  0, 3'b001, 10);
        run_len("t2_n_yellow", 0, 3'b010, 2);
        run_len("t2_allred",   4, 3'b000, 1);
        run_len("t2_e_green",  1, 3'b001, 10);
        run_len("t2_e_yellow", 1, 3'b010, 2);
        run_len("t2_allred2",  4, 3'b000, 1);
        run_len("t2_n_green2", 0, 3'b001, 10);

        // North drops its request in green cycle 1: minimum green.
        set_sens(1'b1, 1'b1, 1'b0, 1'b0);
        do_reset(2);
        wait_for("t3_n_on", 0, 3'b001, 5);
        set_sens(1'b0, 1'b1, 1'b0, 1'b0);
        run_len("t3_n_green",  0, 3'b001, 4);
        run_len("t3_n_yellow", 0, 3'b010, 2);
        run_len("t3_allred",   4, 3'b000, 1);
        check("t3_e_green",  32'(lE), 32'd1);
        check("t3_e_active", 32'(act), 32'd1);

        // All approaches requesting: full round robin back to north.
        set_sens(1'b1, 1'b1, 1'b1, 1'b1);
        do_reset(2);
        for (int k = 0; k < 5; k++) begin
            d = k % 4;
            wait_for($sformatf("t4_on_%0d", k), d, 3'b001, 5);
            check($sformatf("t4_active_%0d", k), 32'(act), 32'(d));
            run_len($sformatf("t4_green_%0d", k),  d, 3'b001, 10);
            run_len($sformatf("t4_yellow_%0d", k), d, 3'b010, 2);
            run_len($sformatf("t4_allred_%0d", k), 4, 3'b000, 1);
        end

        // Idle intersection, then a south request.
        set_sens(1'b0, 1'b0, 1'b0, 1'b0);
        do_reset(2);
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            if (ph == 2'd0 && lN == 3'b100 && lE == 3'b100 && lS == 3'b100 && lW == 3'b100) cnt++;
            step(1);
        end
        check("t5_idle_cycles", 32'(cnt), 32'd50);
        set_sens(1'b0, 1'b0, 1'b1, 1'b0);
        check("t5_s_pending", 32'(lS), 32'd4);
        step(1);
        check("t5_s_green",  32'(lS), 32'd1);
        check("t5_s_active", 32'(act), 32'd2);

        // Emergency for north while west is green at n=2.
        set_sens(1'b0, 1'b0, 1'b0, 1'b1);
        do_reset(2);
        wait_for("t6_w_on", 3, 3'b001, 5);
        step(1);
        em_req = 1'b1;
        em_dir = 2'd0;
        set_sens(1'b0, 1'b1, 1'b1, 1'b1);
        run_len("t6_w_green_rest", 3, 3'b001, EM ? 1 : 9);
        if (EM) begin
            run_len("t6_w_yellow", 3, 3'b010, 2);
            run_len("t6_allred",   4, 3'b000, 1);
            check("t6_em_active", 32'(act), 32'd0);
            cnt = 0;
            for (int k = 0; k < 20; k++) begin
                if (lN == 3'b001) cnt++;
                step(1);
            end
            check("t6_n_held", 32'(cnt), 32'd20);
            em_req = 1'b0;
            wait_for("t6_n_yellow", 0, 3'b010, 5);
        end else begin
            wait_for("t6_w_yellow", 3, 3'b010, 3);
        end
        em_req = 1'b0;
        reset = 1'b1;
        step(1);
        check("t6_rst_light_N", 32'(lN), 32'd4);
        check("t6_rst_light_E", 32'(lE), 32'd4);
        check("t6_rst_light_S", 32'(lS), 32'd4);
        check("t6_rst_light_W", 32'(lW), 32'd4);
        check("t6_rst_phase",   32'(ph), 32'd0);
        check("t6_rst_active",  32'(act), 32'd3);
        reset = 1'b0;
        set_sens(1'b1, 1'b1, 1'b0, 1'b1);
        wait_for("t6_n_after_rst", 0, 3'b001, 5);
        check("t6_n_active", 32'(act), 32'd0);

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
